// File: rtl/gate_test_ctrl.sv
// Sweeps every input vector of an N_IN-input gate under test, compares the
// sampled gate output against the selected function and reports a verdict.
//
// state  | meaning
// IDLE   | waiting for start after reset
// SETTLE | vec driven, waiting SETTLE cycles for the gate to settle
// CHECK  | sample dut_out, compare, advance vec or finish
// DONE   | results held until next start or reset
module gate_test_ctrl #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      gate_sel,
  input  logic            dut_out,
  output logic [N_IN-1:0] vec,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid,
  output logic            cfg_err
);

  localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] VEC_ONE  = {{(N_IN-1){1'b0}}, 1'b1};
  localparam logic [N_IN:0]   ERR_ONE  = {{N_IN{1'b0}}, 1'b1};
  localparam logic [3:0]      CNT_LOAD = 4'(SETTLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  state_t     state, state_nxt;
  logic [2:0] gate_q;
  logic [3:0] cnt;
  logic       exp_val;
  logic       mismatch;
  logic       launch;
  logic       reserved;

  assign launch   = start && ((state == S_IDLE) || (state == S_DONE));
  assign reserved = gate_sel[2] & gate_sel[1];

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = reserved ? S_DONE : S_SETTLE;
      S_SETTLE:       if (cnt == 4'd0) state_nxt = S_CHECK;
      S_CHECK:        state_nxt = (vec == VEC_LAST) ? S_DONE : S_SETTLE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state == S_SETTLE) || (state == S_CHECK);
    done    = (state == S_DONE);
    pass    = done && (err_cnt == '0) && !cfg_err;
    exp_val = 1'b0;
    case (gate_q)
      3'd0:    exp_val = &vec;
      3'd1:    exp_val = |vec;
      3'd2:    exp_val = ~&vec;
      3'd3:    exp_val = ~|vec;
      3'd4:    exp_val = ^vec;
      3'd5:    exp_val = ~^vec;
      default: exp_val = 1'b0;
    endcase
    mismatch = (dut_out != exp_val);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      gate_q           <= '0;
      vec              <= '0;
      cnt              <= '0;
      err_cnt          <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
      cfg_err          <= 1'b0;
    end else if (launch) begin
      gate_q           <= gate_sel;
      vec              <= '0;
      cnt              <= CNT_LOAD;
      err_cnt          <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
      cfg_err          <= reserved;
    end else begin
      case (state)
        S_SETTLE: if (cnt != 4'd0) cnt <= cnt - 4'd1;
        S_CHECK: begin
          if (mismatch) begin
            err_cnt <= err_cnt + ERR_ONE;
            if (!first_fail_valid) begin
              first_fail_vec   <= vec;
              first_fail_valid <= 1'b1;
            end
          end
          // vec holds its last value into DONE
          if (vec != VEC_LAST) begin
            vec <= vec + VEC_ONE;
            cnt <= CNT_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_test_ctrl.sv
// Directed bench for gate_test_ctrl: default instance (N_IN=3, SETTLE=1)
// and an overridden instance (N_IN=2, SETTLE=3) driving an XOR model.
module tb_gate_test_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;

  logic       rst, start, start_b;
  logic [2:0] gate_sel, gate_sel_b;
  logic       dut_out_a, dut_out_b;
  int         mode;

  logic [2:0] vec_a, ffv_a;
  logic [3:0] err_a;
  logic       busy_a, done_a, pass_a, ffok_a, cfg_a;

  logic [1:0] vec_b, ffv_b;
  logic [2:0] err_b;
  logic       busy_b, done_b, pass_b, ffok_b, cfg_b;

  // mode 0: correct AND gate, 1: output stuck at 0
  always_comb dut_out_a = (mode == 0) ? &vec_a : 1'b0;
  always_comb dut_out_b = ^vec_b;

  gate_test_ctrl dut_a (
    .clk(clk), .rst(rst), .start(start), .gate_sel(gate_sel), .dut_out(dut_out_a),
    .vec(vec_a), .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
    .first_fail_vec(ffv_a), .first_fail_valid(ffok_a), .cfg_err(cfg_a));

  gate_test_ctrl #(.N_IN(2), .SETTLE(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .gate_sel(gate_sel_b), .dut_out(dut_out_b),
    .vec(vec_b), .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
    .first_fail_vec(ffv_b), .first_fail_valid(ffok_b), .cfg_err(cfg_b));

  // Start at E0, then step to E0+16 recording vec-trace errors and early done.
  task automatic run_a(input logic [2:0] sel, output int vec_bad, output bit early);
    @(negedge clk); gate_sel = sel; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    vec_bad = (vec_a !== 3'd0) ? 1 : 0;
    early = 1'b0;
    for (int j = 1; j < 16; j++) begin
      @(posedge clk); #1;
      if (vec_a !== 3'(j / 2)) vec_bad++;
      if (done_a !== 1'b0 || busy_a !== 1'b1) early = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic run_b(output int vec_bad, output bit early);
    @(negedge clk); gate_sel_b = 3'd4; start_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0;
    vec_bad = (vec_b !== 2'd0) ? 1 : 0;
    early = 1'b0;
    for (int j = 1; j < 16; j++) begin
      @(posedge clk); #1;
      if (vec_b !== 2'(j / 4)) vec_bad++;
      if (done_b !== 1'b0) early = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; start_b = 1'b1; gate_sel = 3'd0; gate_sel_b = 3'd4;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({vec_a, busy_a, done_a, pass_a, err_a, ffv_a, ffok_a, cfg_a} !== 16'h0)
      $display("FAIL reset_a: outputs=%h required 0",
               {vec_a, busy_a, done_a, pass_a, err_a, ffv_a, ffok_a, cfg_a});
    else pass_cnt++;
    total++;
    if ({vec_b, busy_b, done_b, pass_b, err_b, ffv_b, ffok_b, cfg_b} !== 13'h0)
      $display("FAIL reset_b: outputs=%h required 0",
               {vec_b, busy_b, done_b, pass_b, err_b, ffv_b, ffok_b, cfg_b});
    else pass_cnt++;
    @(negedge clk); rst = 1'b1; start = 1'b0; start_b = 1'b0;
  endtask

  task automatic test_and_pass();
    int  bad;
    bit  early;
    mode = 0;
    run_a(3'd0, bad, early);
    total++; if (early) $display("FAIL and_timing: done/busy wrong before E0+16"); else pass_cnt++;
    total++; if (bad != 0) $display("FAIL and_vec_trace: %0d bad samples, required 0", bad); else pass_cnt++;
    total++; if (done_a !== 1'b1 || busy_a !== 1'b0)
      $display("FAIL and_done: done=%b busy=%b required 1/0", done_a, busy_a); else pass_cnt++;
    total++; if (pass_a !== 1'b1 || err_a !== 4'd0 || ffok_a !== 1'b0)
      $display("FAIL and_result: pass=%b err=%0d ffv=%b required 1/0/0", pass_a, err_a, ffok_a); else pass_cnt++;
    total++; if (vec_a !== 3'd7) $display("FAIL and_vec_hold: vec=%0d required 7", vec_a); else pass_cnt++;
  endtask

  task automatic test_or_mismatch();
    int bad;
    bit early;
    mode = 0;
    run_a(3'd1, bad, early);
    total++; if (err_a !== 4'd6) $display("FAIL or_err_cnt: got %0d required 6", err_a); else pass_cnt++;
    total++; if (ffv_a !== 3'd1 || ffok_a !== 1'b1)
      $display("FAIL or_first_fail: vec=%0d valid=%b required 1/1", ffv_a, ffok_a); else pass_cnt++;
    total++; if (pass_a !== 1'b0 || done_a !== 1'b1)
      $display("FAIL or_verdict: pass=%b done=%b required 0/1", pass_a, done_a); else pass_cnt++;
  endtask

  task automatic test_nand_stuck0();
    int bad;
    bit early;
    mode = 1;
    run_a(3'd2, bad, early);
    total++; if (err_a !== 4'd7) $display("FAIL nand_err_cnt: got %0d required 7", err_a); else pass_cnt++;
    total++; if (ffv_a !== 3'd0 || ffok_a !== 1'b1)
      $display("FAIL nand_first_fail: vec=%0d valid=%b required 0/1", ffv_a, ffok_a); else pass_cnt++;
    total++; if (pass_a !== 1'b0) $display("FAIL nand_pass: got %b required 0", pass_a); else pass_cnt++;
  endtask

  task automatic test_cfg_err();
    int bad;
    bit early;
    mode = 0;
    @(negedge clk); gate_sel = 3'd6; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    total++;
    if ({done_a, cfg_a, pass_a, busy_a, err_a, vec_a} !== {4'b1100, 4'd0, 3'd0})
      $display("FAIL cfg_abort: done=%b cfg=%b pass=%b busy=%b err=%0d vec=%0d required 1/1/0/0/0/0",
               done_a, cfg_a, pass_a, busy_a, err_a, vec_a);
    else pass_cnt++;
    run_a(3'd0, bad, early);
    total++; if (cfg_a !== 1'b0 || pass_a !== 1'b1 || done_a !== 1'b1 || bad != 0)
      $display("FAIL cfg_recover: cfg=%b pass=%b done=%b vec_bad=%0d required 0/1/1/0",
               cfg_a, pass_a, done_a, bad);
    else pass_cnt++;
  endtask

  task automatic test_mid_run();
    mode = 0;
    @(negedge clk); gate_sel = 3'd0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int j = 1; j < 16; j++) begin
      @(posedge clk); #1;
      start = (j == 6);
      if (j == 6) gate_sel = 3'd1;
    end
    start = 1'b0;
    @(posedge clk); #1;
    total++; if (done_a !== 1'b1 || pass_a !== 1'b1 || err_a !== 4'd0)
      $display("FAIL midrun_ignore: done=%b pass=%b err=%0d required 1/1/0", done_a, pass_a, err_a);
    else pass_cnt++;

    gate_sel = 3'd0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      @(posedge clk); #1;
    end
    total++; if (vec_a !== 3'd5 || busy_a !== 1'b1)
      $display("FAIL midrun_pos: vec=%0d busy=%b required 5/1", vec_a, busy_a); else pass_cnt++;
    rst = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({vec_a, busy_a, done_a, pass_a, err_a, ffv_a, ffok_a, cfg_a} !== 16'h0)
      $display("FAIL midrun_reset: outputs=%h required 0",
               {vec_a, busy_a, done_a, pass_a, err_a, ffv_a, ffok_a, cfg_a});
    else pass_cnt++;
    rst = 1'b1; start = 1'b0;
    begin
      int bad;
      bit early;
      run_a(3'd0, bad, early);
      total++; if (pass_a !== 1'b1 || done_a !== 1'b1 || bad != 0 || early)
        $display("FAIL midrun_rerun: pass=%b done=%b vec_bad=%0d early=%b required 1/1/0/0",
                 pass_a, done_a, bad, early);
      else pass_cnt++;
    end
  endtask

  task automatic test_param_xor();
    int bad;
    bit early;
    for (int r = 0; r < 2; r++) begin
      run_b(bad, early);
      total++; if (early || done_b !== 1'b1)
        $display("FAIL xor_timing_%0d: early=%b done=%b required 0/1", r, early, done_b); else pass_cnt++;
      total++; if (bad != 0) $display("FAIL xor_vec_trace_%0d: %0d bad samples, required 0", r, bad); else pass_cnt++;
      total++; if (pass_b !== 1'b1 || err_b !== 3'd0 || ffok_b !== 1'b0 || vec_b !== 2'd3)
        $display("FAIL xor_result_%0d: pass=%b err=%0d ffv=%b vec=%0d required 1/0/0/3",
                 r, pass_b, err_b, ffok_b, vec_b);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    bit early;
    mode = 1;
    run_a(3'd2, bad, early);
    mode = 0;
    run_a(3'd0, bad, early);
    total++; if (err_a !== 4'd0 || ffok_a !== 1'b0 || pass_a !== 1'b1 || bad != 0)
      $display("FAIL b2b_clear: err=%0d ffv=%b pass=%b vec_bad=%0d required 0/0/1/0",
               err_a, ffok_a, pass_a, bad);
    else pass_cnt++;
  endtask

  initial begin
    mode = 0;
    test_reset();
    test_and_pass();
    test_or_mismatch();
    test_nand_stuck0();
    test_cfg_err();
    test_mid_run();
    test_param_xor();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
